// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - access-size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as word)
//   - FSM state enum (IDLE, WAIT)
//   - helpers: alignment check, byte-enable generation, store-data
//     replication and load lane extraction with sign/zero extension
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_e;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addrLo[0];
            default: return (addrLo != 2'b00);
        endcase
    endfunction

    // Byte lanes touched by an access; little-endian, lane 0 = bits 7:0.
    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            SZ_BYTE: return 4'b0001 << addrLo;
            SZ_HALF: return addrLo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is right-aligned; replicating it puts the right bytes on
    // every lane so the byte enables alone decide what is written.
    function automatic logic [31:0] storeSteer(input logic [31:0] data, input logic [1:0] size);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] laneExtract(input logic [31:0] word, input logic [1:0] addrLo,
                                                input logic [1:0] size, input logic zeroExt);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {addrLo, 3'b000};
        b       = shifted[7:0];
        h       = addrLo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return zeroExt ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: return zeroExt ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM request bundle and MEM/WB result bundle of the stage.
//   slave  : the MEM stage (consumes ex-side signals, drives stall and wb_*)
//   master : upstream pipeline / WB side
//
// Flow control: the instruction presented on the ex-side signals (qualified
// by ex_valid) is consumed at the first rising clock edge where mem_stall is
// low; while mem_stall is high the upstream stages must hold it unchanged.
// wb_valid qualifies the MEM/WB outputs for exactly one cycle per instruction.
// dbgState exposes the stage FSM state (mem_stage_pkg::memState_e encoding).
interface mem_stage_if #(parameter int REG_W = 5);
    logic             ex_valid;
    logic [31:0]      alu_result;
    logic [31:0]      write_data;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             mem_read;
    logic [1:0]       mem_size;
    logic             load_unsigned;
    logic [REG_W-1:0] write_reg;

    logic             mem_stall;
    logic             wb_valid;
    logic [31:0]      wb_read_data;
    logic [31:0]      wb_result;
    logic [REG_W-1:0] wb_write_reg;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic             misalign;
    logic [0:0]       dbgState;

    modport master (
        output ex_valid, alu_result, write_data, reg_write, mem_to_reg, mem_write,
               mem_read, mem_size, load_unsigned, write_reg,
        input  mem_stall, wb_valid, wb_read_data, wb_result, wb_write_reg,
               wb_reg_write, wb_mem_to_reg, misalign, dbgState
    );

    modport slave (
        input  ex_valid, alu_result, write_data, reg_write, mem_to_reg, mem_write,
               mem_read, mem_size, load_unsigned, write_reg,
        output mem_stall, wb_valid, wb_read_data, wb_result, wb_write_reg,
               wb_reg_write, wb_mem_to_reg, misalign, dbgState
    );
endinterface

// File: rtl/mem_stage_data_ram.sv
// data_ram: DEPTH x 32-bit data memory with per-byte write enables.
//   clk      clock
//   wrEn     write strobe, commits on the rising edge
//   byteEn   byte-lane enables (lane 0 = bits 7:0)
//   wordAddr word index
//   wrData   write data (already steered onto lanes)
//   rdData   combinational read of wordAddr
// Contents are not reset.
module data_ram #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [3:0]    byteEn,
    input  logic [AW-1:0] wordAddr,
    input  logic [31:0]   wrData,
    output logic [31:0]   rdData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordAddr][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

    assign rdData = mem[wordAddr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a byte-addressable data RAM and a
// configurable number of wait states per access.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : mem_stage_if.slave -- EX/MEM request in, mem_stall and the
//              registered MEM/WB outputs (wb_*, misalign) out, dbgState
// Parameters: DEPTH (RAM words, power of two >= 4), LATENCY (0..15 wait
// states), REG_W (register index width).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int REG_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_WAIT  = WAIT;

    logic [0:0] state;
    logic [3:0] cnt;

    // Request latched when entering WAIT; upstream is stalled meanwhile
    // but the access is served from this copy so the inputs may be ignored.
    logic [31:0]      reqAddr, reqData;
    logic             reqRegWrite, reqMemToReg, reqMemWrite, reqMemRead, reqUnsigned;
    logic [1:0]       reqSize;
    logic [REG_W-1:0] reqWriteReg;

    // The instruction being worked on this cycle.
    logic             curValid, curRegWrite, curMemToReg, curMemWrite, curMemRead, curUnsigned;
    logic [31:0]      curAddr, curData;
    logic [1:0]       curSize;
    logic [REG_W-1:0] curWriteReg;

    always_comb begin
        curValid    = bus.ex_valid;
        curAddr     = bus.alu_result;
        curData     = bus.write_data;
        curRegWrite = bus.reg_write;
        curMemToReg = bus.mem_to_reg;
        curMemWrite = bus.mem_write;
        curMemRead  = bus.mem_read;
        curSize     = bus.mem_size;
        curUnsigned = bus.load_unsigned;
        curWriteReg = bus.write_reg;
        if (state == ST_WAIT) begin
            curValid    = 1'b1;
            curAddr     = reqAddr;
            curData     = reqData;
            curRegWrite = reqRegWrite;
            curMemToReg = reqMemToReg;
            curMemWrite = reqMemWrite;
            curMemRead  = reqMemRead;
            curSize     = reqSize;
            curUnsigned = reqUnsigned;
            curWriteReg = reqWriteReg;
        end
    end

    logic curMemOp, curMis, startWait, stall, complete;

    assign curMemOp  = curValid & (curMemRead | curMemWrite);
    assign curMis    = curMemOp & isMisaligned(curSize, curAddr[1:0]);
    assign startWait = (state == ST_IDLE) && curMemOp && !curMis && (LATENCY > 0);
    assign stall     = (state == ST_IDLE) ? startWait : (cnt != 4'd0);
    assign complete  = ~stall;

    assign bus.mem_stall = stall & ~rst;

    // RAM access. A store with mem_read also set is still just a store.
    logic        ramWe;
    logic [31:0] ramRdata;
    logic [31:0] loadData;

    assign ramWe = complete & curMemOp & curMemWrite & ~curMis & ~rst;

    data_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .wrEn     (ramWe),
        .byteEn   (byteEnable(curSize, curAddr[1:0])),
        .wordAddr (curAddr[AW+1:2]),
        .wrData   (storeSteer(curData, curSize)),
        .rdData   (ramRdata)
    );

    assign loadData = (curMemOp && curMemRead && !curMemWrite && !curMis)
                    ? laneExtract(ramRdata, curAddr[1:0], curSize, curUnsigned)
                    : 32'd0;

    // FSM and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            reqAddr     <= 32'd0;
            reqData     <= 32'd0;
            reqRegWrite <= 1'b0;
            reqMemToReg <= 1'b0;
            reqMemWrite <= 1'b0;
            reqMemRead  <= 1'b0;
            reqSize     <= SZ_BYTE;
            reqUnsigned <= 1'b0;
            reqWriteReg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (startWait) begin
                        state       <= ST_WAIT;
                        cnt         <= CNT_INIT;
                        reqAddr     <= curAddr;
                        reqData     <= curData;
                        reqRegWrite <= curRegWrite;
                        reqMemToReg <= curMemToReg;
                        reqMemWrite <= curMemWrite;
                        reqMemRead  <= curMemRead;
                        reqSize     <= curSize;
                        reqUnsigned <= curUnsigned;
                        reqWriteReg <= curWriteReg;
                    end
                end
                default: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else             state <= ST_IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: stalled edges and invalid slots load a bubble.
    logic             wbValid, wbRegWrite, wbMemToReg, wbMisalign;
    logic [31:0]      wbReadData, wbResult;
    logic [REG_W-1:0] wbWriteReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            wbMemToReg <= 1'b0;
            wbMisalign <= 1'b0;
            wbReadData <= 32'd0;
            wbResult   <= 32'd0;
            wbWriteReg <= '0;
        end else if (complete && curValid) begin
            wbValid    <= 1'b1;
            wbRegWrite <= curRegWrite & ~curMis;
            wbMemToReg <= curMemToReg;
            wbMisalign <= curMis;
            wbReadData <= loadData;
            wbResult   <= curAddr;
            wbWriteReg <= curWriteReg;
        end else begin
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            wbMemToReg <= 1'b0;
            wbMisalign <= 1'b0;
            wbReadData <= 32'd0;
            wbResult   <= 32'd0;
            wbWriteReg <= '0;
        end
    end

    assign bus.wb_valid      = wbValid;
    assign bus.wb_reg_write  = wbRegWrite;
    assign bus.wb_mem_to_reg = wbMemToReg;
    assign bus.misalign      = wbMisalign;
    assign bus.wb_read_data  = wbReadData;
    assign bus.wb_result     = wbResult;
    assign bus.wb_write_reg  = wbWriteReg;
    assign bus.dbgState      = state;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: bench for mem_stage. DUT A uses LATENCY=2, DEPTH=256; DUT B
// uses LATENCY=0, DEPTH=16. Expected results come from hand-written vectors
// and from a byte-array memory model.
`timescale 1ns/1ps
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DEPTH   = 256;
    localparam int LAT     = 2;
    localparam int REG_W   = 5;
    localparam int DEPTH_B = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if #(.REG_W(REG_W)) busA ();
    mem_stage_if #(.REG_W(REG_W)) busB ();

    mem_stage #(.DEPTH(DEPTH), .LATENCY(LAT), .REG_W(REG_W)) dutA (
        .clk (clk), .rst (rst), .bus (busA.slave)
    );
    mem_stage #(.DEPTH(DEPTH_B), .LATENCY(0), .REG_W(REG_W)) dutB (
        .clk (clk), .rst (rst), .bus (busB.slave)
    );

    // ---------------- types ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw, m2r, mw, mr;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  wreg;
    } op_t;

    typedef struct packed {
        logic        valid, regWrite, memToReg, mis;
        logic [31:0] readData, result;
        logic [4:0]  wreg;
        logic [3:0]  stalls;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t want;
    } vec_t;

    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    vec_t             vecs[$];
    logic [7:0]       modelMem[DEPTH*4];
    int               nTests = 0;
    int               nFail  = 0;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic op_t opStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        op_t o;
        o = '0; o.valid = 1'b1; o.addr = a; o.data = d; o.mw = 1'b1; o.size = sz;
        return o;
    endfunction

    function automatic op_t opLoad(input logic [31:0] a, input logic [1:0] sz, input logic u,
                                   input logic [4:0] r);
        op_t o;
        o = '0; o.valid = 1'b1; o.addr = a; o.mr = 1'b1; o.rw = 1'b1; o.m2r = 1'b1;
        o.size = sz; o.uns = u; o.wreg = r;
        return o;
    endfunction

    function automatic op_t opAlu(input logic [31:0] a, input logic [4:0] r);
        op_t o;
        o = '0; o.valid = 1'b1; o.addr = a; o.rw = 1'b1; o.wreg = r;
        return o;
    endfunction

    function automatic exp_t mkExp(input logic v, input logic rw, input logic m2r, input logic mis,
                                   input logic [31:0] rd, input logic [31:0] res,
                                   input logic [4:0] r, input logic [3:0] st);
        exp_t e;
        e.valid = v; e.regWrite = rw; e.memToReg = m2r; e.mis = mis;
        e.readData = rd; e.result = res; e.wreg = r; e.stalls = st;
        return e;
    endfunction

    task automatic addVec(input op_t o, input exp_t e);
        vec_t v;
        v.op = o; v.want = e;
        vecs.push_back(v);
    endtask

    // Reference model: memory as a flat little-endian byte array.
    function automatic exp_t modelOp(input op_t op);
        exp_t        e;
        int          nb, base;
        logic        isMem, mis;
        logic [63:0] v, mask;
        e = '0;
        if (!op.valid) return e;
        nb    = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
        isMem = op.mr || op.mw;
        mis   = isMem && ((int'(op.addr[1:0]) % nb) != 0);
        e.valid = 1'b1; e.regWrite = op.rw && !mis; e.memToReg = op.m2r; e.mis = mis;
        e.result = op.addr; e.wreg = op.wreg;
        e.stalls = (isMem && !mis) ? 4'(LAT) : 4'd0;
        if (isMem && !mis) begin
            base = int'(op.addr % (DEPTH*4));
            if (op.mw) begin
                for (int i = 0; i < nb; i++) modelMem[base+i] = op.data[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < nb; i++) v = v | (64'(modelMem[base+i]) << (8*i));
                mask = (64'd1 << (8*nb)) - 64'd1;
                if (!op.uns && v[8*nb-1]) v = v | ~mask;
                e.readData = v[31:0];
            end
        end
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic driveA(input op_t o);
        busA.ex_valid = o.valid;   busA.alu_result = o.addr;  busA.write_data = o.data;
        busA.reg_write = o.rw;     busA.mem_to_reg = o.m2r;   busA.mem_write = o.mw;
        busA.mem_read = o.mr;      busA.mem_size = o.size;    busA.load_unsigned = o.uns;
        busA.write_reg = o.wreg;
    endtask

    task automatic driveB(input op_t o);
        busB.ex_valid = o.valid;   busB.alu_result = o.addr;  busB.write_data = o.data;
        busB.reg_write = o.rw;     busB.mem_to_reg = o.m2r;   busB.mem_write = o.mw;
        busB.mem_read = o.mr;      busB.mem_size = o.size;    busB.load_unsigned = o.uns;
        busB.write_reg = o.wreg;
    endtask

    // Present op at a negedge, count stall cycles, sample wb_* one cycle
    // after acceptance and compare with the head of the expected queue.
    task automatic runOp(input op_t o);
        exp_t e;
        int   stalls;
        driveA(o);
        #1;
        stalls = 0;
        while (busA.mem_stall === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk); #1;
        end
        if (stalls >= 40) begin
            nTests++; nFail++;
            $display("FAIL stall_timeout: got %0d stall cycles, expected at most %0d", stalls, LAT);
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
            nTests++; nFail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = exp_t'(exp_q.pop_front());
        check("stall_cycles", stalls, 32'(e.stalls));
        check("wb_valid", busA.wb_valid, e.valid);
        check("wb_reg_write", busA.wb_reg_write, e.regWrite);
        check("misalign", busA.misalign, e.mis);
        if (e.valid) begin
            check("wb_mem_to_reg", busA.wb_mem_to_reg, e.memToReg);
            check("wb_result", busA.wb_result, e.result);
            check("wb_write_reg", 32'(busA.wb_write_reg), 32'(e.wreg));
            if (!e.mis) check("wb_read_data", busA.wb_read_data, e.readData);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        op_t         o;
        op_t         bub;
        int          kind;
        int          idx;
        logic [31:0] d;

        for (int i = 0; i < DEPTH*4; i++) modelMem[i] = 8'd0;
        bub = '0;

        // Directed vectors (DUT A, LATENCY=2), applied back-to-back.
        addVec(opStore(32'h10, 32'hDEADBEEF, SZ_WORD), mkExp(1,0,0,0, 32'h0,        32'h10,   5'd0, 4'd2));
        addVec(opLoad (32'h10, SZ_WORD, 1'b0, 5'd3),   mkExp(1,1,1,0, 32'hDEADBEEF, 32'h10,   5'd3, 4'd2));
        addVec(opStore(32'h10, 32'h11223344, SZ_WORD), mkExp(1,0,0,0, 32'h0,        32'h10,   5'd0, 4'd2));
        addVec(opStore(32'h13, 32'hAAAAAA80, SZ_BYTE), mkExp(1,0,0,0, 32'h0,        32'h13,   5'd0, 4'd2));
        addVec(opLoad (32'h10, SZ_WORD, 1'b0, 5'd4),   mkExp(1,1,1,0, 32'h80223344, 32'h10,   5'd4, 4'd2));
        addVec(opLoad (32'h13, SZ_BYTE, 1'b0, 5'd5),   mkExp(1,1,1,0, 32'hFFFFFF80, 32'h13,   5'd5, 4'd2));
        addVec(opLoad (32'h13, SZ_BYTE, 1'b1, 5'd5),   mkExp(1,1,1,0, 32'h00000080, 32'h13,   5'd5, 4'd2));
        addVec(opLoad (32'h12, SZ_HALF, 1'b0, 5'd6),   mkExp(1,1,1,0, 32'hFFFF8022, 32'h12,   5'd6, 4'd2));
        addVec(opLoad (32'h12, SZ_HALF, 1'b1, 5'd6),   mkExp(1,1,1,0, 32'h00008022, 32'h12,   5'd6, 4'd2));
        addVec(opLoad (32'h11, SZ_HALF, 1'b0, 5'd6),   mkExp(1,0,1,1, 32'h0,        32'h11,   5'd6, 4'd0));
        addVec(opAlu  (32'h1234, 5'd7),                mkExp(1,1,0,0, 32'h0,        32'h1234, 5'd7, 4'd0));
        addVec(opLoad (32'h10, SZ_WORD, 1'b0, 5'd8),   mkExp(1,1,1,0, 32'h80223344, 32'h10,   5'd8, 4'd2));
        addVec(opStore(32'h400, 32'h55AA1234, SZ_WORD),mkExp(1,0,0,0, 32'h0,        32'h400,  5'd0, 4'd2));
        addVec(opLoad (32'h000, SZ_WORD, 1'b0, 5'd9),  mkExp(1,1,1,0, 32'h55AA1234, 32'h0,    5'd9, 4'd2));
        o = opLoad(32'h10, SZ_WORD, 1'b0, 5'd1); o.valid = 1'b0;
        addVec(o,                                      mkExp(0,0,0,0, 32'h0,        32'h0,    5'd0, 4'd0));
        addVec(opStore(32'h22, 32'h1111BEEF, SZ_HALF), mkExp(1,0,0,0, 32'h0,        32'h22,   5'd0, 4'd2));
        o = opStore(32'h21, 32'h0000007F, SZ_BYTE); o.mr = 1'b1; o.wreg = 5'd10;
        addVec(o,                                      mkExp(1,0,0,0, 32'h0,        32'h21,   5'd10, 4'd2));
        addVec(opStore(32'h22, 32'h12345678, SZ_WORD), mkExp(1,0,0,1, 32'h0,        32'h22,   5'd0, 4'd0));
        addVec(opLoad (32'h20, SZ_WORD, 1'b1, 5'd11),  mkExp(1,1,1,0, 32'hBEEF7F00, 32'h20,   5'd11, 4'd2));
        addVec(opLoad (32'h21, SZ_BYTE, 1'b0, 5'd12),  mkExp(1,1,1,0, 32'h0000007F, 32'h21,   5'd12, 4'd2));
        addVec(opLoad (32'h10, 2'b11, 1'b0, 5'd13),    mkExp(1,1,1,0, 32'h80223344, 32'h10,   5'd13, 4'd2));
        addVec(opLoad (32'h12, 2'b11, 1'b0, 5'd14),    mkExp(1,0,1,1, 32'h0,        32'h12,   5'd14, 4'd0));

        // Reset state.
        driveA(bub);
        driveB(bub);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wb_valid", busA.wb_valid, 1'b0);
        check("rst_mem_stall", busA.mem_stall, 1'b0);
        check("rst_wb_read_data", busA.wb_read_data, 32'h0);
        check("rst_wb_result", busA.wb_result, 32'h0);
        check("rst_misalign", busA.misalign, 1'b0);
        check("rst_state", 32'(busA.dbgState), 32'(IDLE));
        rst = 1'b0;

        foreach (vecs[i]) begin
            exp_q.push_back(EXP_W'(vecs[i].want));
            void'(modelOp(vecs[i].op));
            runOp(vecs[i].op);
        end

        // Reset in the middle of a store's WAIT: the store must be dropped.
        driveA(opStore(32'h20, 32'hCAFEF00D, SZ_WORD));
        #1 check("rstwait_stall_before", busA.mem_stall, 1'b1);
        @(negedge clk); #1;
        check("rstwait_state_wait", 32'(busA.dbgState), 32'(WAIT));
        rst = 1'b1;
        #1;
        check("rstwait_mem_stall", busA.mem_stall, 1'b0);
        check("rstwait_wb_valid", busA.wb_valid, 1'b0);
        check("rstwait_state_idle", 32'(busA.dbgState), 32'(IDLE));
        @(negedge clk);
        driveA(bub);
        rst = 1'b0;
        exp_q.push_back(EXP_W'(mkExp(1,1,1,0, 32'hBEEF7F00, 32'h20, 5'd2, 4'd2)));
        void'(modelOp(opLoad(32'h20, SZ_WORD, 1'b0, 5'd2)));
        runOp(opLoad(32'h20, SZ_WORD, 1'b0, 5'd2));
        driveA(bub);

        // DUT B: LATENCY=0, DEPTH=16 -- no stall ever, addresses wrap at 64.
        for (int i = 0; i < 6; i++) begin
            idx = $urandom_range(0, DEPTH_B-1);
            d   = $urandom();
            driveB(opStore(32'(idx*4 + 64*$urandom_range(1, 3)), d, SZ_WORD));
            #1 check("b_store_stall", busB.mem_stall, 1'b0);
            @(negedge clk);
            check("b_store_valid", busB.wb_valid, 1'b1);
            driveB(opLoad(32'(idx*4), SZ_WORD, 1'b0, 5'd1));
            #1 check("b_load_stall", busB.mem_stall, 1'b0);
            @(negedge clk);
            check("b_load_valid", busB.wb_valid, 1'b1);
            check("b_load_data", busB.wb_read_data, d);
        end
        driveB(bub);

        // Random traffic on DUT A against the model.
        for (int n = 0; n < 300; n++) begin
            o       = '0;
            o.valid = ($urandom_range(0, 9) != 0);
            o.addr  = 32'($urandom_range(0, 95));
            if ($urandom_range(0, 3) == 0) o.addr = o.addr + 32'h400 * $urandom_range(1, 3);
            o.data  = $urandom();
            o.size  = 2'($urandom_range(0, 3));
            o.uns   = 1'($urandom_range(0, 1));
            o.wreg  = 5'($urandom_range(0, 31));
            kind    = $urandom_range(0, 3);
            case (kind)
                0: o.mw = 1'b1;
                1: begin o.mr = 1'b1; o.rw = 1'b1; o.m2r = 1'b1; end
                2: o.rw = 1'b1;
                default: begin o.mw = 1'b1; o.mr = 1'b1; end
            endcase
            exp_q.push_back(EXP_W'(modelOp(o)));
            runOp(o);
        end
        driveA(bub);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised MEM pipeline stage for the 5-stage MIPS core: replaces the single-cycle, word-only memory stage. It owns a byte-addressable data RAM and supports byte, halfword and word accesses with sign or zero extension. It models a multi-cycle memory with a configurable wait-state count, stalling upstream stages while an access is in flight. It registers the MEM/WB pipeline outputs and flags misaligned accesses.

## Interface
Parameters:
- DEPTH, 256, data RAM size in 32-bit words; power of two, at least 4
- LATENCY, 2, wait states per memory access, 0..15
- REG_W, 5, register-index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- alu_result  in  32  byte address for memory ops; pass-through result otherwise
- write_data  in  32  store data, right-aligned
- reg_write, mem_to_reg, mem_write, mem_read  in  1 each  control bits from EX/MEM
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- load_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads
- write_reg  in  REG_W  destination register
- mem_stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM
- wb_valid  out  1  MEM/WB holds a valid instruction
- wb_read_data, wb_result  out  32 each  load data; alu_result pass-through
- wb_write_reg  out  REG_W  destination register
- wb_reg_write, wb_mem_to_reg  out  1 each  control bits to WB
- misalign  out  1  registered; high for one cycle alongside wb_valid

## Operation
- A memory op is ex_valid with mem_read or mem_write set.
- Misaligned access:
  - half with addr[0]=1, or word with addr[1:0]≠0.
  - No RAM write and no stall.
  - wb_reg_write forced to 0; misalign=1.
- RAM indexing:
  - word index = alu_result[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH·4.
  - Byte order is little-endian.
- Stores:
  - byte writes write_data[7:0] to lane addr[1:0].
  - half writes write_data[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - word writes all four lanes.
  - Other lanes are unchanged.
- Loads: extract the lane(s) selected as for stores, then sign- or zero-extend to 32 bits.
- wb_read_data is 0 when the instruction is not a load.
- mem_read and mem_write both set: treated as a store only; wb_read_data=0.
- FSM, two states:
  - IDLE, to WAIT: aligned memory op and LATENCY>0. The full request (address, data, controls, size) is latched and cnt is loaded with LATENCY−1.
  - IDLE, otherwise: the instruction completes this cycle.
  - WAIT: inputs are ignored. If cnt≠0, cnt decrements. If cnt=0, the access completes from the latched request and the state returns to IDLE.
- mem_stall:
  - IDLE: high iff an aligned memory op is present and LATENCY>0.
  - WAIT: high iff cnt≠0.
- MEM/WB register:
  - Loads on every non-stalled edge.
  - On stalled edges it loads a bubble (wb_valid=0, wb_reg_write=0, misalign=0).
  - ex_valid=0 in IDLE produces a bubble.
- RAM contents are not reset. The RAM comes up in simulation with all words 0.

## Timing
- Non-memory op, or LATENCY=0: one cycle. wb_* is valid the cycle after the instruction is presented. Writes commit at that same edge.
- Memory op with LATENCY=L>0, presented in cycle 0:
  - mem_stall is high in cycles 0..L−1.
  - In cycle L the state is WAIT with cnt=0 and mem_stall=0.
  - At the end-of-cycle-L edge the RAM write commits, wb_* loads, and the upstream pipeline advances.
  - wb_valid=1 in cycle L+1.
- Back-to-back memory ops: the second op enters IDLE in cycle L+1 and starts a new L-cycle stall. There is no dead cycle between them.
- Load immediately after a store to the same word: returns the stored data, because the write committed before the load's access cycle.
- Reset (asynchronous, any time, including mid-WAIT):
  - state=IDLE, cnt=0.
  - wb_valid, wb_reg_write, wb_mem_to_reg, misalign = 0.
  - wb_read_data, wb_result = 0; wb_write_reg = 0.
  - mem_stall low once rst is asserted.
  - Any pending store is dropped; the RAM is unchanged.

## Structure
- Package mem_stage_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state enum (IDLE, WAIT)
  - lane-extract/extend function
- Sub-module data_ram:
  - parametrised DEPTH × 32 array
  - 4-bit byte enable, synchronous write, combinational read
- mem_stage contains the FSM, the request latch, alignment check, lane steering and the MEM/WB register.

## Test plan
- LATENCY=2, store word 0xDEADBEEF to 0x10, then load word from 0x10 → mem_stall high 2 cycles per op; wb_read_data=0xDEADBEEF with wb_valid three cycles after each op is presented.
- Store byte 0x80 to 0x13 over a word holding 0x11223344 → word becomes 0x80223344. Signed byte load of 0x13 gives 0xFFFFFF80; unsigned gives 0x00000080.
- Halfword load from 0x12 of 0x80223344 → signed 0xFFFF8022, unsigned 0x00008022. Halfword load from 0x11 → misalign=1, wb_reg_write=0, no stall.
- ALU op (reg_write=1, alu_result=0x1234) between two loads → wb_result=0x1234 one cycle after it is presented, with no stall.
- Assert rst during the WAIT of a store of 0xCAFEF00D to 0x20 → wb_valid=0 and mem_stall=0 immediately; a later load of 0x20 returns its prior value.
- DEPTH=256, store word to 0x400 then load 0x000 → same word (wrap-around); with LATENCY=0 there is no stall at all.
